// File: rtl/wb_write_buffer.sv
// Register-file write-port arbiter: pipeline write-backs win, multiply/divide results wait in a FIFO.
// Define WB_HAZARD_EN to build the per-entry RAW hazard compare; otherwise hazard1/hazard2 read 0.
module wb_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wbEn,
    input  logic [4:0]               wbDest,
    input  logic [31:0]              wbVal,
    input  logic                     mdValid,
    input  logic [4:0]               mdDest,
    input  logic [31:0]              mdVal,
    output logic                     mdReady,
    input  logic [4:0]               src1,
    input  logic [4:0]               src2,
    output logic                     hazard1,
    output logic                     hazard2,
    output logic [4:0]               dest,
    output logic [31:0]              writeVal,
    output logic                     writeEn,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] valid_reg;
    logic [DEPTH-1:0] valid_next;
    logic [4:0]       ent_dest_reg [DEPTH];
    logic [31:0]      ent_val_reg  [DEPTH];
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW-1:0]    wr_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic [4:0]       dest_reg;
    logic [31:0]      wval_reg;
    logic             we_reg;

    logic wb_commit;
    logic push;
    logic pop;
    logic head_valid;

    assign mdReady    = !rst && (count_reg < CW'(DEPTH));
    assign wb_commit  = wbEn && (wbDest != 5'd0);
    // r0 results complete the handshake but never occupy a slot
    assign push       = mdValid && mdReady && (mdDest != 5'd0);
    assign pop        = !wb_commit && (count_reg != '0);
    assign head_valid = valid_reg[rd_ptr_reg];
    assign count_next = count_reg + CW'(push) - CW'(pop);

    // Squash only hits entries already present; the slot being filled this edge stays valid.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
            assign valid_next[gi] = (push && (wr_ptr_reg == PW'(gi))) ||
                                    (valid_reg[gi] &&
                                     !(wb_commit && (ent_dest_reg[gi] == wbDest)) &&
                                     !(pop && (rd_ptr_reg == PW'(gi))));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            dest_reg   <= 5'd0;
            wval_reg   <= 32'd0;
            we_reg     <= 1'b0;
        end else begin
            valid_reg <= valid_next;
            count_reg <= count_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            if (wb_commit) begin
                dest_reg <= wbDest;
                wval_reg <= wbVal;
                we_reg   <= 1'b1;
            end else if (pop && head_valid) begin
                dest_reg <= ent_dest_reg[rd_ptr_reg];
                wval_reg <= ent_val_reg[rd_ptr_reg];
                we_reg   <= 1'b1;
            end else begin
                // squashed pop or idle: dest/writeVal keep their last values
                we_reg <= 1'b0;
            end
        end
    end

    // Payload storage needs no reset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_dest_reg[wr_ptr_reg] <= mdDest;
            ent_val_reg[wr_ptr_reg]  <= mdVal;
        end
    end

`ifdef WB_HAZARD_EN
    logic [DEPTH-1:0] hit1;
    logic [DEPTH-1:0] hit2;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hazard
            assign hit1[gi] = valid_reg[gi] && (ent_dest_reg[gi] == src1);
            assign hit2[gi] = valid_reg[gi] && (ent_dest_reg[gi] == src2);
        end
    endgenerate

    assign hazard1 = (src1 != 5'd0) && (|hit1);
    assign hazard2 = (src2 != 5'd0) && (|hit2);
`else
    logic unused_src;

    assign unused_src = ^{src1, src2};
    assign hazard1    = 1'b0;
    assign hazard2    = 1'b0;
`endif

    assign dest     = dest_reg;
    assign writeVal = wval_reg;
    assign writeEn  = we_reg;
    assign count    = count_reg;

endmodule

// File: tb/tb_wb_write_buffer.sv
// Self-checking bench for wb_write_buffer: expected register-file writes are queued when the
// stimulus is driven and popped by a negedge monitor whenever writeEn is seen.
module tb_wb_write_buffer;
    localparam int DEPTH = 4;
`ifdef WB_HAZARD_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wbEn;
    logic [4:0]  wbDest;
    logic [31:0] wbVal;
    logic        mdValid;
    logic [4:0]  mdDest;
    logic [31:0] mdVal;
    logic        mdReady;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic        hazard1;
    logic        hazard2;
    logic [4:0]  dest;
    logic [31:0] writeVal;
    logic        writeEn;
    logic [$clog2(DEPTH):0] count;

    int tests = 0;
    int fails = 0;
    logic [36:0] exp_q[$];

    wb_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wbEn(wbEn), .wbDest(wbDest), .wbVal(wbVal),
        .mdValid(mdValid), .mdDest(mdDest), .mdVal(mdVal), .mdReady(mdReady),
        .src1(src1), .src2(src2), .hazard1(hazard1), .hazard2(hazard2),
        .dest(dest), .writeVal(writeVal), .writeEn(writeEn), .count(count)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every observed write must match the oldest expected one.
    always @(negedge clk) begin
        if (writeEn === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL write_unexpected: got r%0d=%h, required no write", dest, writeVal);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({dest, writeVal} !== e) begin
                    fails++;
                    $display("FAIL write_order: got r%0d=%h, required r%0d=%h",
                             dest, writeVal, e[36:32], e[31:0]);
                end else begin
                    $display("[TB] write r%0d=%h", dest, writeVal);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // One clock: apply inputs, note whether the md offer is accepted, settle past the edge.
    task automatic drive(input bit we, input logic [4:0] wd, input logic [31:0] wv,
                         input bit mv, input logic [4:0] md, input logic [31:0] mval,
                         output bit acc);
        wbEn = we; wbDest = wd; wbVal = wv;
        mdValid = mv; mdDest = md; mdVal = mval;
        #1;
        acc = mv && (mdReady === 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        bit acc;
        src1 = 5'd1; src2 = 5'd2;
        rst = 1'b1;
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, acc);
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, acc);
        tests++;
        if (writeEn !== 1'b0 || dest !== 5'd0 || writeVal !== 32'd0 || count !== 3'd0 || mdReady !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got we=%b dest=%0d val=%h count=%0d rdy=%b, required 0 0 0 0 0",
                     writeEn, dest, writeVal, count, mdReady);
        end
        rst = 1'b0; wbEn = 1'b0; mdValid = 1'b0;
        #1;
        if (mdReady !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b, required 1", mdReady); end
        tests++;
        if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin
            fails++;
            $display("FAIL reset_hazard: got %b%b, required 00", hazard1, hazard2);
        end
        tests++;
        $display("[TB] reset checked");
    endtask

    task automatic test_priority();
        bit acc;
        @(posedge clk); #1;
        exp_q.push_back({5'd7, 32'h77});
        drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd5, 32'hAAAA0005, acc);
        chk("prio_accept", 32'(acc), 32'd1);
        chk("prio_count1", 32'(count), 32'd1);
        exp_q.push_back({5'd5, 32'hAAAA0005});
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
        chk("prio_count0", 32'(count), 32'd0);
    endtask

    task automatic test_full_wrap();
        bit acc;
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back({5'd3, 32'h300 + 32'(i)});
            drive(1'b1, 5'd3, 32'h300 + 32'(i), 1'b1, 5'(8 + i), 32'h800 + 32'(i), acc);
            chk("fill_accept", 32'(acc), 32'd1);
        end
        chk("full_ready", 32'(mdReady), 32'd0);
        chk("full_count", 32'(count), 32'(DEPTH));
        exp_q.push_back({5'd3, 32'h3FF});
        drive(1'b1, 5'd3, 32'h3FF, 1'b1, 5'd16, 32'h1600, acc);
        chk("starve_accept", 32'(acc), 32'd0);
        chk("starve_count", 32'(count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) exp_q.push_back({5'(8 + i), 32'h800 + 32'(i)});
        for (int j = 0; j < DEPTH; j++) begin
            int tries = 0;
            acc = 1'b0;
            while (!acc && tries < 10) begin
                drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(16 + j), 32'h1600 + 32'(j), acc);
                tries++;
            end
            chk("wrap_accept", 32'(acc), 32'd1);
            if (acc) exp_q.push_back({5'(16 + j), 32'h1600 + 32'(j)});
        end
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
        chk("wrap_drained", 32'(exp_q.size()), 32'd0);
        chk("wrap_count", 32'(count), 32'd0);
    endtask

    task automatic test_squash();
        bit acc;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h1, acc);
        chk("squash_count1", 32'(count), 32'd1);
        exp_q.push_back({5'd9, 32'h2});
        drive(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'd0, acc);
        chk("squash_count_kept", 32'(count), 32'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
        chk("squash_we", 32'(writeEn), 32'd0);
        chk("squash_count0", 32'(count), 32'd0);
        chk("squash_dest_held", {27'd0, dest}, 32'd9);
        chk("squash_val_held", writeVal, 32'h2);
    endtask

    task automatic test_reg0();
        bit acc;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44, acc);
        exp_q.push_back({5'd4, 32'h44});
        drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0, acc);
        chk("r0_drain_we", 32'(writeEn), 32'd1);
        chk("r0_drain_count", 32'(count), 32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBEEF, acc);
        chk("r0_md_accept", 32'(acc), 32'd1);
        chk("r0_md_count", 32'(count), 32'd0);
        chk("r0_md_we", 32'(writeEn), 32'd0);
    endtask

    task automatic test_hazard();
        bit acc;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC, acc);
        src1 = 5'd12; src2 = 5'd0;
        #1;
        chk("hazard1_set", 32'(hazard1), 32'(HZ));
        chk("hazard2_r0", 32'(hazard2), 32'd0);
        src2 = 5'd12;
        #1;
        chk("hazard2_set", 32'(hazard2), 32'(HZ));
        src2 = 5'd0;
        exp_q.push_back({5'd12, 32'hC});
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
        chk("hazard1_clear", 32'(hazard1), 32'd0);
    endtask

    task automatic test_reset_mid_drain();
        bit acc;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'h20, acc);
        exp_q.push_back({5'd20, 32'h20});
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd21, 32'h21, acc);
        chk("middrain_count", 32'(count), 32'd1);
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
        chk("middrain_we", 32'(writeEn), 32'd0);
        chk("middrain_count0", 32'(count), 32'd0);
        rst = 1'b0;
        #1;
        chk("middrain_ready", 32'(mdReady), 32'd1);
        for (int c = 0; c < 3; c++) drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
    endtask

    initial begin
        rst = 1'b0; wbEn = 1'b0; wbDest = '0; wbVal = '0;
        mdValid = 1'b0; mdDest = '0; mdVal = '0; src1 = '0; src2 = '0;
        test_reset();
        test_priority();
        test_full_wrap();
        test_squash();
        test_reg0();
        test_hazard();
        test_reset_mid_drain();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL final_drain: got %0d pending writes, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
